// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Holds the init-sequence state encoding and the per-entry init value rule.
package regfile_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAX_READ = 4;

  // Value loaded into entry 'index' during initialisation, truncated to 'width' bits.
  function automatic logic [63:0] init_value(input int unsigned index,
                                             input logic        mode,
                                             input int unsigned width);
    logic [63:0] value;
    value = mode ? 64'(index) : 64'd0;
    if (width < 64) begin
      value = value & ((64'd1 << width) - 64'd1);
    end
    return value;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: hardwired-zero entry, optional write bypass,
// and output forced to zero until the file is ready.
module regfile_read_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);

  logic wr_hit;

  assign wr_hit = wr_en && (wr_addr == addr);

  // NOTE: registered state uses non-blocking assignments so every port samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || !active) begin
      data <= '0;
    end else if (addr == '0) begin
      data <= '0;
    end else if ((BYPASS != 0) && wr_hit) begin
      data <= wr_data;
    end else begin
      data <= mem_data;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file with NUM_READ registered read ports, one write port,
// hardwired-zero entry 0 and a counter-driven initialisation sweep after reset.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_MODE  = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rdAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdData,
  input  logic                           wrEn,
  input  logic [ADDR_WIDTH-1:0]          wrAddr,
  input  logic [DATA_WIDTH-1:0]          wrData,
  output logic                           ready
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

  if (NUM_READ < 1 || NUM_READ > MAX_READ) begin : g_bad_num_read
    $error("register_file_mp: NUM_READ must be between 1 and MAX_READ");
  end

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] init_data;
  logic                  active;
  logic                  wr_ok;

  assign active    = (state == READY);
  assign wr_ok     = active && wrEn && (wrAddr != '0);
  assign init_data = DATA_WIDTH'(init_value(32'(cnt), (INIT_MODE != 0), DATA_WIDTH));

  // Counter carries one extra bit so the exit compare sees DEPTH-1 before any wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_IDX) begin
        state <= READY;
        ready <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; the init sweep defines its contents instead.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[cnt[ADDR_WIDTH-1:0]] <= init_data;
      end else if (wr_ok) begin
        mem[wrAddr] <= wrData;
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] mem_data;

    assign addr     = rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_data = mem[addr];

    regfile_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .BYPASS    (BYPASS)
    ) u_port (
      .clock   (clock),
      .reset   (reset),
      .active  (active),
      .addr    (addr),
      .mem_data(mem_data),
      .wr_en   (wr_ok),
      .wr_addr (wrAddr),
      .wr_data (wrData),
      .data    (rdData[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
